// File: rtl/mmio_byte_port_pkg.sv
// Shared register map for the MMIO byte port: offsets, STATUS/CTRL bit positions,
// default window base and the STATUS word packer used by the read path.
package mmio_byte_port_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FF00;

  // Word index inside the 16-byte window, taken from addr[3:2].
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_FULL      = 2;
  localparam int ST_RX_EMPTY     = 3;
  localparam int ST_TX_OVF       = 4;
  localparam int ST_RX_UDF       = 5;
  localparam int ST_TX_COUNT_LSB = 8;
  localparam int ST_RX_COUNT_LSB = 16;

  localparam int CTRL_CLEAR_FLAGS = 0;
  localparam int CTRL_FLUSH_TX    = 1;
  localparam int CTRL_FLUSH_RX    = 2;

  function automatic logic [31:0] pack_status(
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_full,
    input logic       rx_empty,
    input logic       tx_ovf,
    input logic       rx_udf,
    input logic [7:0] tx_count,
    input logic [7:0] rx_count
  );
    logic [31:0] s;
    s                          = '0;
    s[ST_TX_FULL]              = tx_full;
    s[ST_TX_EMPTY]             = tx_empty;
    s[ST_RX_FULL]              = rx_full;
    s[ST_RX_EMPTY]             = rx_empty;
    s[ST_TX_OVF]               = tx_ovf;
    s[ST_RX_UDF]               = rx_udf;
    s[ST_TX_COUNT_LSB +: 8]    = tx_count;
    s[ST_RX_COUNT_LSB +: 8]    = rx_count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_byte_port_fifo.sv
// Byte FIFO with push/pop/flush; full/empty/count reflect pre-edge state and the
// head byte is visible combinationally so a pop can be captured on the same edge.
module mmio_byte_port_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Flush dominates; push into a full FIFO is refused even if a pop frees a slot.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mmio_byte_port.sv
// CPU memory-bus responder for a 16-byte I/O window bridging loads/stores to a
// TX byte FIFO and an RX byte FIFO; read data is registered with one-cycle latency.
module mmio_byte_port
  import mmio_byte_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        rd_hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          hit, wr_hit, rd_now;
  reg_sel_e      sel;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          flush_tx, flush_rx, clear_flags;
  logic          ovf_event, udf_event;
  logic [7:0]    tx_head, rx_head;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_udf_q, rx_udf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rd_hit_q, rd_hit_d;
  logic          unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  always_comb begin
    hit         = (addr[31:4] == BASE_ADDR[31:4]) && (mem_read || mem_write);
    wr_hit      = hit && mem_write;
    // A simultaneous read and write is treated as a write only.
    rd_now      = hit && mem_read && !mem_write;
    sel         = reg_sel_e'(addr[3:2]);
    clear_flags = wr_hit && (sel == REG_CTRL) && wdata[CTRL_CLEAR_FLAGS];
    flush_tx    = wr_hit && (sel == REG_CTRL) && wdata[CTRL_FLUSH_TX];
    flush_rx    = wr_hit && (sel == REG_CTRL) && wdata[CTRL_FLUSH_RX];
    tx_push     = wr_hit && (sel == REG_DATA);
    tx_pop      = !tx_empty && tx_ready;
    rx_pop      = rd_now && (sel == REG_DATA);
    rx_push     = rx_valid && !rx_full;
    ovf_event   = tx_push && tx_full && !flush_tx;
    udf_event   = rx_pop && rx_empty && !flush_rx;
    tx_ovf_d    = (tx_ovf_q && !clear_flags) || ovf_event;
    rx_udf_d    = (rx_udf_q && !clear_flags) || udf_event;
    rd_hit_d    = rd_now;
    rdata_d     = '0;
    if (rd_now) begin
      unique case (sel)
        REG_DATA:   rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        REG_STATUS: rdata_d = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                          tx_ovf_q, rx_udf_q,
                                          8'(tx_count), 8'(rx_count));
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      rdata_q  <= '0;
      rd_hit_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
      rdata_q  <= rdata_d;
      rd_hit_q <= rd_hit_d;
    end
  end

  mmio_byte_port_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (tx_push),
    .pop     (tx_pop),
    .flush   (flush_tx),
    .wr_data (wdata[7:0]),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  mmio_byte_port_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rx_push),
    .pop     (rx_pop),
    .flush   (flush_rx),
    .wr_data (rx_data),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  assign rdata    = rdata_q;
  assign rd_hit   = rd_hit_q;
  assign tx_data  = tx_head;
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

endmodule
